// File: rtl/mem_responder.sv
// Single-outstanding memory responder with WAIT_CYCLES wait states and a held response.
// Define MEM_RESP_CHECK_EN to reject illegal byte-enables and out-of-range addresses.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            access;
    logic            req_err;
    logic [IdxW-1:0] idx;

    assign accept = req_valid && (state_q == StIdle);
    assign access = (state_q == StBusy) && (cnt_q == '0);
    assign idx    = addr_q[2 +: IdxW];

`ifdef MEM_RESP_CHECK_EN
    logic be_bad;
    logic addr_bad;
    logic unused_addr;

    always_comb begin
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_bad = 1'b0;
            default:                   be_bad = 1'b1;
        endcase
    end

    assign addr_bad    = (addr_q >> 2) >= 32'(DEPTH_WORDS);
    assign req_err     = be_bad || addr_bad;
    assign unused_addr = ^addr_q[1:0];
`else
    logic unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    assign req_err     = 1'b0;
    assign unused_addr = ^{addr_q[1:0], addr_q[31:IdxW+2]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Holding registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (access && we_q && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid)    state_d = StBusy;
            StBusy:  if (cnt_q == '0)  state_d = StResp;
            StResp:  if (resp_ready)   state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d = CntW'(WAIT_CYCLES);
        end else if ((state_q == StBusy) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (access) begin
            err_d   = req_err;
            rdata_d = (req_err || we_q) ? 32'h0 : mem[idx];
        end
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance share stimulus,
// selected by sel; expected responses flow through a scoreboard queue.
module tb_mem_responder;
    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;

    logic        a_ready, a_valid, a_err;
    logic        b_ready, b_valid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        rdy, rvalid, rerr;
    logic [31:0] rdata;

    int          errors = 0;
    int          checks = 0;
    longint      cyc = 0;
    logic [32:0] sb[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdy    = sel ? b_ready : a_ready;
    assign rvalid = sel ? b_valid : a_valid;
    assign rerr   = sel ? b_err   : a_err;
    assign rdata  = sel ? b_rdata : a_rdata;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(a_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(a_valid), .resp_ready(resp_ready), .resp_rdata(a_rdata), .resp_err(a_err)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(b_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(b_valid), .resp_ready(resp_ready), .resp_rdata(b_rdata), .resp_err(b_err)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.sel = s; v.we = w; v.addr = a; v.wdata = d; v.be = b;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Entered and left at a negedge with the selected DUT idle.
    task automatic txn(input vec_t v, input int hold, input string tag, output longint acc);
        logic [32:0] e;
        int          lat;
        sel        = v.sel;
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_be     = v.be;
        #1;
        chk({tag, " req_ready"}, 32'(rdy), 32'd1);
        @(negedge clk);
        acc = cyc;
        sb.push_back({v.exp_rdata, v.exp_err});
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), v.sel ? 32'd1 : 32'd3);
        e = sb.pop_front();
        chk({tag, " rdata"}, rdata, e[32:1]);
        chk({tag, " err"}, 32'(rerr), 32'(e[0]));
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            @(negedge clk);
            chk({tag, " held valid"}, 32'(rvalid), 32'd1);
            chk({tag, " held rdata"}, rdata, e[32:1]);
            chk({tag, " held ready"}, 32'(rdy), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " post valid"}, 32'(rvalid), 32'd0);
        chk({tag, " post ready"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc, prev;
        vec_t   v;

        vecs.push_back(mk(1, 1, 32'h4,   32'h44444444, 4'hF, 32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h8,   32'h88888888, 4'hF, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h4,   32'h0,        4'hF, 32'h44444444, 0));
        vecs.push_back(mk(1, 0, 32'h8,   32'h0,        4'hF, 32'h88888888, 0));
        vecs.push_back(mk(0, 1, 32'h0,   32'hDEADBEEF, 4'hF, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,        4'hF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 32'h10,  32'h11223344, 4'hF, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h10,  32'hAABBCCDD, 4'h4, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h10,  32'h0,        4'hF, 32'h11BB3344, 0));
        vecs.push_back(mk(0, 0, 32'h13,  32'h0,        4'hF, 32'h11BB3344, 0));
        vecs.push_back(mk(0, 1, 32'h14,  32'hFFFFFFFF, 4'hF, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h14,  32'h12345678, 4'h3, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h14,  32'h9A000000, 4'h8, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h14,  32'h0,        4'hF, 32'h9AFF5678, 0));
        vecs.push_back(mk(0, 1, 32'h18,  32'h0,        4'hF, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h18,  32'h000000AB, 4'h1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h18,  32'h0000CD00, 4'h2, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h18,  32'h0,        4'hF, 32'h0000CDAB, 0));
        vecs.push_back(mk(0, 1, 32'h20,  32'h01020304, 4'hF, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'hFFC, 32'h0,        4'hF, 32'h0BADF00D, 0));
        vecs.push_back(mk(0, 0, 32'h20,  32'h0,        4'hF, 32'h01020304, 0));

        sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; resp_ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst a ready", 32'(a_ready), 32'd1);
        chk("rst a valid", 32'(a_valid), 32'd0);
        chk("rst a rdata", a_rdata, 32'h0);
        chk("rst a err", 32'(a_err), 32'd0);
        chk("rst b ready", 32'(b_ready), 32'd1);
        chk("rst b valid", 32'(b_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        prev = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i], 0, $sformatf("v%0d", i), acc);
            if (i > 0 && vecs[i-1].sel == vecs[i].sel)
                chk($sformatf("v%0d spacing", i), 32'(acc - prev), vecs[i].sel ? 32'd3 : 32'd5);
            prev = acc;
        end

        txn(mk(0, 0, 32'h10, 32'h0, 4'hF, 32'h11BB3344, 0), 5, "hold", acc);

        // Reset one cycle after accepting a write: the write must never land.
        sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(negedge clk);
        chk("rstmid accepted", 32'(a_ready), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid valid", 32'(a_valid), 32'd0);
        chk("rstmid ready", 32'(a_ready), 32'd1);
        chk("rstmid rdata", a_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid idle valid", 32'(a_valid), 32'd0);
        chk("rstmid idle ready", 32'(a_ready), 32'd1);
        txn(mk(0, 0, 32'h20, 32'h0, 4'hF, 32'h01020304, 0), 0, "rstmid read", acc);

`ifdef MEM_RESP_CHECK_EN
        txn(mk(0, 1, 32'h1000, 32'h55667788, 4'hF, 32'h0, 1), 0, "oob write", acc);
        txn(mk(0, 0, 32'h0,    32'h0,        4'hF, 32'hDEADBEEF, 0), 0, "oob mem0", acc);
        txn(mk(0, 0, 32'h1000, 32'h0,        4'hF, 32'h0, 1), 0, "oob read", acc);
        txn(mk(0, 1, 32'h10,   32'hFFFFFFFF, 4'h5, 32'h0, 1), 0, "bad be", acc);
        txn(mk(0, 0, 32'h10,   32'h0,        4'hF, 32'h11BB3344, 0), 0, "bad be mem", acc);
`else
        txn(mk(0, 1, 32'h1000, 32'h55667788, 4'hF, 32'h0, 0), 0, "wrap write", acc);
        txn(mk(0, 0, 32'h0,    32'h0,        4'hF, 32'h55667788, 0), 0, "wrap mem0", acc);
        txn(mk(0, 1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0, 0), 0, "be0 write", acc);
        txn(mk(0, 0, 32'h10,   32'h0,        4'hF, 32'h11BB3344, 0), 0, "be0 mem", acc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
